// File: rtl/card_pkg.sv
// rtl/card_pkg.sv - shared card deck constants, dealer state type and card decode functions
//
// Purpose:
//   Common definitions for the card dealer, the score display and the game FSM.
//   A card index idx runs 0..51; suit = idx / 13, rank = idx mod 13 + 1.
//
// Contents:
//   DECK_SIZE, RANKS, SUITS  deck geometry constants
//   state_t                  dealer FSM states (IDLE, PROBE, DONE)
//   idx_to_suit              card index -> suit 0..3
//   idx_to_rank              card index -> rank 1..13 (1=Ace, 11=J, 12=Q, 13=K)
//   rank_to_value            rank -> Blackjack score value (Ace=1, J/Q/K=10)

package card_pkg;

  localparam int DECK_SIZE = 52;
  localparam int RANKS     = 13;
  localparam int SUITS     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Threshold compares instead of a divide: the index only spans 0..51.
  function automatic logic [1:0] idx_to_suit(input logic [5:0] idx);
    logic [1:0] suit;
    if (idx >= 6'(3 * RANKS))      suit = 2'd3;
    else if (idx >= 6'(2 * RANKS)) suit = 2'd2;
    else if (idx >= 6'(RANKS))     suit = 2'd1;
    else                           suit = 2'd0;
    return suit;
  endfunction

  function automatic logic [3:0] idx_to_rank(input logic [5:0] idx);
    logic [5:0] base;
    case (idx_to_suit(idx))
      2'd0:    base = 6'd0;
      2'd1:    base = 6'(RANKS);
      2'd2:    base = 6'(2 * RANKS);
      default: base = 6'(3 * RANKS);
    endcase
    return 4'(idx - base + 6'd1);
  endfunction

  function automatic logic [3:0] rank_to_value(input logic [3:0] rank);
    return (rank > 4'd10) ? 4'd10 : rank;
  endfunction

endpackage

// File: rtl/card_decode.sv
// rtl/card_decode.sv - combinational card index to rank/value/suit decoder
//
// Purpose:
//   Turns a deck index 0..51 into the displayable card fields. Purely
//   combinational so the score display can reuse it directly.
//
// Ports:
//   i_Idx    in   6  card index 0..51
//   o_Rank   out  4  rank 1..13
//   o_Value  out  4  Blackjack score value 1..10
//   o_Suit   out  2  suit 0..3

module card_decode
  import card_pkg::*;
(
  input  logic [5:0] i_Idx,
  output logic [3:0] o_Rank,
  output logic [3:0] o_Value,
  output logic [1:0] o_Suit
);

  logic [3:0] w_rank;

  assign w_rank  = idx_to_rank(i_Idx);
  assign o_Rank  = w_rank;
  assign o_Value = rank_to_value(w_rank);
  assign o_Suit  = idx_to_suit(i_Idx);

endmodule

// File: rtl/card_dealer.sv
// rtl/card_dealer.sv - deals unique cards from a 52-card deck seeded by the game counter
//
// Purpose:
//   On a deal request the low six counter bits pick a starting index; the
//   dealer then probes forward (wrapping 51 -> 0) through the used bitmap one
//   slot per clock until it finds a free card, marks it used and presents it
//   with a one-cycle valid pulse. Shuffle clears the deck and aborts a deal.
//
// Optional feature (macro CARD_DEALER_REMAINING_EN):
//   When defined, adds o_Remaining = 52 - cards dealt.
//
// Ports:
//   clk_50M      in   1      system clock
//   i_Reset      in   1      asynchronous active-low reset
//   i_Count      in   WIDTH  free-running counter used as seed (unsigned)
//   i_Deal       in   1      deal request
//   i_Shuffle    in   1      synchronous deck clear / deal abort
//   o_Card       out  4      rank 1..13, 0 before the first deal
//   o_Value      out  4      Blackjack score value
//   o_Suit       out  2      suit 0..3
//   o_Valid      out  1      one-cycle pulse, card outputs are new
//   o_Busy       out  1      deal in progress
//   o_DeckEmpty  out  1      all 52 cards dealt
//   o_Remaining  out  6      cards left (only with CARD_DEALER_REMAINING_EN)

module card_dealer
  import card_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic             clk_50M,
  input  logic             i_Reset,
  input  logic [WIDTH-1:0] i_Count,
  input  logic             i_Deal,
  input  logic             i_Shuffle,
  output logic [3:0]       o_Card,
  output logic [3:0]       o_Value,
  output logic [1:0]       o_Suit,
  output logic             o_Valid,
  output logic             o_Busy,
  output logic             o_DeckEmpty
`ifdef CARD_DEALER_REMAINING_EN
  ,
  output logic [5:0]       o_Remaining
`endif
);

  state_t                 r_state;
  state_t                 w_next;
  logic [DECK_SIZE-1:0]   r_used;
  logic [5:0]             r_idx;
  logic [5:0]             r_count;
  logic                   r_empty;
  logic [3:0]             r_card;
  logic [3:0]             r_value;
  logic [1:0]             r_suit;

  logic                   w_start;
  logic                   w_hit;
  logic                   w_step;
  logic [5:0]             w_seed;
  logic [5:0]             w_seed_idx;
  logic [5:0]             w_step_idx;
  logic [3:0]             w_rank;
  logic [3:0]             w_value;
  logic [1:0]             w_suit;

  // Only the low six counter bits seed the deal; the rest are intentionally ignored.
  generate
    if (WIDTH > 6) begin : g_unused
      logic w_unused_count;
      assign w_unused_count = ^i_Count[WIDTH-1:6];
    end
  endgenerate

  // 52..63 fold onto 0..11 with a subtract rather than a modulo.
  assign w_seed     = i_Count[5:0];
  assign w_seed_idx = (w_seed < 6'(DECK_SIZE)) ? w_seed : w_seed - 6'(DECK_SIZE);
  assign w_step_idx = (r_idx == 6'(DECK_SIZE - 1)) ? 6'd0 : r_idx + 6'd1;

  card_decode u_decode (
    .i_Idx   (r_idx),
    .o_Rank  (w_rank),
    .o_Value (w_value),
    .o_Suit  (w_suit)
  );

  always_ff @(posedge clk_50M or negedge i_Reset) begin
    if (!i_Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_hit   = 1'b0;
    w_step  = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_Deal && !r_empty) begin
          w_next  = PROBE;
          w_start = 1'b1;
        end
      end
      PROBE: begin
        // Entry to PROBE guarantees a free slot, so this loop always terminates.
        if (!r_used[r_idx]) begin
          w_next = DONE;
          w_hit  = 1'b1;
        end else begin
          w_step = 1'b1;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
    // Shuffle overrides everything, including a same-cycle deal request.
    if (i_Shuffle) begin
      w_next  = IDLE;
      w_start = 1'b0;
      w_hit   = 1'b0;
      w_step  = 1'b0;
    end
  end

  always_ff @(posedge clk_50M or negedge i_Reset) begin
    if (!i_Reset) begin
      r_used  <= '0;
      r_idx   <= 6'd0;
      r_count <= 6'd0;
      r_empty <= 1'b0;
      r_card  <= 4'd0;
      r_value <= 4'd0;
      r_suit  <= 2'd0;
    end else if (i_Shuffle) begin
      // Card outputs deliberately keep the last dealt card.
      r_used  <= '0;
      r_count <= 6'd0;
      r_empty <= 1'b0;
    end else begin
      if (w_start) begin
        r_idx <= w_seed_idx;
      end
      if (w_step) begin
        r_idx <= w_step_idx;
      end
      if (w_hit) begin
        r_used[r_idx] <= 1'b1;
        r_count       <= r_count + 6'd1;
        r_empty       <= (r_count == 6'(DECK_SIZE - 1));
        r_card        <= w_rank;
        r_value       <= w_value;
        r_suit        <= w_suit;
      end
    end
  end

  assign o_Card      = r_card;
  assign o_Value     = r_value;
  assign o_Suit      = r_suit;
  assign o_Valid     = (r_state == DONE);
  assign o_Busy      = (r_state != IDLE);
  assign o_DeckEmpty = r_empty;

`ifdef CARD_DEALER_REMAINING_EN
  assign o_Remaining = 6'(DECK_SIZE) - r_count;
`endif

endmodule

// File: tb/tb_card_dealer.sv
// tb/tb_card_dealer.sv - self-checking bench for card_dealer with a deck-level reference model

module tb_card_dealer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] i_Count = '0;
  logic        i_Deal = 1'b0;
  logic        i_Shuffle = 1'b0;
  logic [3:0]  o_Card;
  logic [3:0]  o_Value;
  logic [1:0]  o_Suit;
  logic        o_Valid;
  logic        o_Busy;
  logic        o_DeckEmpty;
`ifdef CARD_DEALER_REMAINING_EN
  logic [5:0]  o_Remaining;
`endif

  int errors = 0;
  int checks = 0;

  always #10 clk = ~clk;

  card_dealer #(.WIDTH(12)) dut (
    .clk_50M     (clk),
    .i_Reset     (rst_n),
    .i_Count     (i_Count),
    .i_Deal      (i_Deal),
    .i_Shuffle   (i_Shuffle),
    .o_Card      (o_Card),
    .o_Value     (o_Value),
    .o_Suit      (o_Suit),
    .o_Valid     (o_Valid),
    .o_Busy      (o_Busy),
    .o_DeckEmpty (o_DeckEmpty)
`ifdef CARD_DEALER_REMAINING_EN
    ,
    .o_Remaining (o_Remaining)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: a deal accepted at edge e with start index i0 finishes
  // at edge e+1+k, where k is the number of used cards walked over from i0.
  bit [51:0] m_used;
  int        m_count;
  bit        m_empty, m_busy, m_valid;
  int        m_idx;
  longint    m_fin;
  longint    ecnt = 0;
  int        m_card, m_value, m_suit;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_used = '0; m_count = 0; m_empty = 0; m_busy = 0; m_valid = 0;
      m_card = 0; m_value = 0; m_suit = 0;
    end else begin
      ecnt++;
      if (i_Shuffle) begin
        m_used = '0; m_count = 0; m_empty = 0; m_busy = 0; m_valid = 0;
      end else if (m_valid) begin
        m_valid = 0; m_busy = 0;
      end else if (m_busy) begin
        if (ecnt == m_fin) begin
          m_used[m_idx] = 1'b1;
          m_count++;
          m_card  = m_idx % 13 + 1;
          m_suit  = m_idx / 13;
          m_value = (m_card > 10) ? 10 : m_card;
          m_empty = (m_count == 52);
          m_valid = 1;
        end
      end else if (i_Deal && !m_empty) begin
        int s, i0, k;
        s  = int'(i_Count) % 64;
        i0 = (s < 52) ? s : s - 52;
        k  = 0;
        while (m_used[(i0 + k) % 52]) k++;
        m_idx  = (i0 + k) % 52;
        m_fin  = ecnt + 1 + k;
        m_busy = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("outputs_vs_model",
          {51'd0, o_Card, o_Value, o_Suit, o_Valid, o_Busy, o_DeckEmpty},
          {51'd0, 4'(m_card), 4'(m_value), 2'(m_suit), m_valid, m_busy, m_empty});
`ifdef CARD_DEALER_REMAINING_EN
      chk("remaining_vs_model", 64'(o_Remaining), 64'(52 - m_count));
`endif
    end
  end

  task automatic do_deal(input int cnt, output int lat, output bit got);
    @(negedge clk);
    i_Count = 12'(cnt);
    i_Deal  = 1'b1;
    @(negedge clk);
    i_Deal = 1'b0;
    lat = 1;
    got = 0;
    for (int c = 0; c < 80; c++) begin
      if (o_Valid) begin
        got = 1;
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_shuffle();
    @(negedge clk);
    i_Shuffle = 1'b1;
    @(negedge clk);
    i_Shuffle = 1'b0;
  endtask

  task automatic deal_expect(input string name, input int cnt, input int card, input int value,
                             input int suit, input int exp_lat);
    int lat;
    bit got;
    do_deal(cnt, lat, got);
    chk({name, "_valid"}, 64'(got), 64'd1);
    chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({name, "_card"}, 64'(o_Card), 64'(card));
    chk({name, "_value"}, 64'(o_Value), 64'(value));
    chk({name, "_suit"}, 64'(o_Suit), 64'(suit));
  endtask

  initial begin
    int lat;
    bit got;
    bit saw_valid;

    i_Count = 12'd37;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", {o_Card, o_Value, o_Suit, o_Valid, o_Busy, o_DeckEmpty}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    deal_expect("seed37", 37, 12, 10, 2, 2);
    deal_expect("seed60", 60, 9, 9, 0, 2);
    deal_expect("seed8_probe", 8, 10, 10, 0, 3);

    do_shuffle();
    chk("shuffle_holds_card", 64'(o_Card), 64'd10);

    for (int i = 0; i < 52; i++) begin
      do_deal(0, lat, got);
      if (!got) begin
        chk("full_deck_valid", 64'(got), 64'd1);
      end else begin
        chk("full_deck_latency", 64'(lat), 64'(2 + i));
        chk("full_deck_card", 64'({o_Suit, o_Card}), 64'({2'(i / 13), 4'(i % 13 + 1)}));
      end
    end
    @(negedge clk);
    chk("deck_empty", 64'(o_DeckEmpty), 64'd1);
    do_deal(0, lat, got);
    chk("deal_when_empty", 64'(got), 64'd0);
    chk("busy_when_empty", 64'(o_Busy), 64'd0);

    do_shuffle();
    chk("empty_after_shuffle", 64'(o_DeckEmpty), 64'd0);
    for (int i = 0; i < 30; i++) do_deal(0, lat, got);
    @(negedge clk);
    i_Count = 12'd0;
    i_Deal  = 1'b1;
    @(negedge clk);
    i_Deal = 1'b0;
    repeat (10) @(negedge clk);
    i_Shuffle = 1'b1;
    @(negedge clk);
    i_Shuffle = 1'b0;
    saw_valid = 0;
    for (int c = 0; c < 60; c++) begin
      if (o_Valid) saw_valid = 1;
      @(negedge clk);
    end
    chk("abort_no_valid", 64'(saw_valid), 64'd0);
    chk("abort_busy", 64'(o_Busy), 64'd0);
    chk("abort_empty", 64'(o_DeckEmpty), 64'd0);
    deal_expect("after_abort", 0, 1, 1, 0, 2);

    @(negedge clk);
    i_Count   = 12'd5;
    i_Deal    = 1'b1;
    i_Shuffle = 1'b1;
    @(negedge clk);
    i_Deal    = 1'b0;
    i_Shuffle = 1'b0;
    chk("deal_shuffle_clash_busy", 64'(o_Busy), 64'd0);
    deal_expect("after_clash", 13, 1, 1, 1, 2);

    // Seed bits above [5:0] must not matter: 0xFC0 | 63 -> idx 11 (Q of suit 0).
    deal_expect("high_bits_ignored", 12'hFFF, 12, 10, 0, 2);

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      i_Count   = 12'($urandom);
      i_Deal    = ($urandom_range(0, 1) == 1);
      i_Shuffle = (c < 2000) ? ($urandom_range(0, 199) == 0) : ($urandom_range(0, 15) == 0);
    end
    @(negedge clk);
    i_Deal = 1'b0;
    i_Shuffle = 1'b0;

    do_shuffle();
    for (int i = 0; i < 20; i++) do_deal(0, lat, got);
    @(negedge clk);
    i_Count = 12'd0;
    i_Deal  = 1'b1;
    @(negedge clk);
    i_Deal = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {o_Card, o_Value, o_Suit, o_Valid, o_Busy, o_DeckEmpty}, 64'd0);
`ifdef CARD_DEALER_REMAINING_EN
    chk("async_reset_remaining", 64'(o_Remaining), 64'd52);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 0;
    for (int c = 0; c < 30; c++) begin
      if (o_Valid) saw_valid = 1;
      @(negedge clk);
    end
    chk("reset_abort_no_valid", 64'(saw_valid), 64'd0);
    deal_expect("after_reset", 51, 13, 10, 3, 2);
`ifdef CARD_DEALER_REMAINING_EN
    chk("remaining_after_one", 64'(o_Remaining), 64'd51);
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/card_dealer.md
Name: card_dealer

Overview:
- Downstream consumer of the free-running game counter.
- Samples the counter value on a deal request and turns it into one card from a single 52-card deck.
- Tracks which cards have already been dealt so no card repeats until the next shuffle.
- Delivers rank, Blackjack score value and suit to the game FSM with a one-cycle valid pulse.

Parameters:
- WIDTH, 12: width of the counter sample input i_Count; must be >= 6.

Ports:
- clk_50M  in  1  50 MHz system clock; the block's only clock.
- i_Reset  in  1  asynchronous, active-low reset.
- i_Count  in  WIDTH  counter value used as the random seed; treated as unsigned.
- i_Deal  in  1  deal request, sampled each clk_50M edge.
- i_Shuffle  in  1  synchronous deck clear and abort.
- o_Card  out  4  rank 1..13 (1=Ace, 11=J, 12=Q, 13=K); 0 when none dealt.
- o_Value  out  4  Blackjack score value: Ace=1, 2..10 = face value, J/Q/K=10.
- o_Suit  out  2  suit index 0..3.
- o_Valid  out  1  one-cycle pulse: o_Card, o_Value and o_Suit are new.
- o_Busy  out  1  high while a deal is in progress (PROBE or DONE).
- o_DeckEmpty  out  1  high when all 52 cards have been dealt.

Behaviour:
- Reset (i_Reset=0, asynchronous):
  - state=IDLE, used bitmap=0, idx=0, dealt count=0.
  - o_Card=0, o_Value=0, o_Suit=0, o_Valid=0, o_Busy=0, o_DeckEmpty=0.
- Deck model: 52-bit used bitmap; card index idx 0..51; rank = idx mod 13 + 1; suit = idx / 13.
- Seed mapping (no divider): s = i_Count[5:0]; idx = s if s < 52, else s - 52. So 52..63 maps to 0..11; this bias is accepted.
- States:
  - IDLE: o_Busy=0. If i_Deal=1 and deck not empty, latch idx from i_Count in the same cycle and go to PROBE. i_Deal while empty is ignored and the state stays IDLE.
  - PROBE: o_Busy=1.
    - If used[idx]=0: set used[idx]=1, register o_Card/o_Value/o_Suit, increment dealt count, go to DONE.
    - Else: idx = (idx==51) ? 0 : idx+1 and stay in PROBE.
    - A card is always found, because entry to PROBE requires at least one free card.
  - DONE: o_Valid=1 and o_Busy=1 for exactly this cycle; go to IDLE.
- Latency: i_Deal sampled at edge N → o_Valid high in cycle N+2+k, where k = number of used slots skipped. Maximum k is 51.
- i_Deal is ignored while o_Busy=1; no queueing. A level-held i_Deal starts a new deal on the first IDLE cycle after DONE.
- i_Shuffle=1 on any edge:
  - Clears used bitmap and dealt count; state goes to IDLE.
  - Any in-flight deal is aborted with no o_Valid.
  - o_Card/o_Value/o_Suit hold their last values.
  - Has priority over a simultaneous i_Deal, which is dropped.
- o_DeckEmpty is registered. It is high from the cycle after the 52nd card is marked used, until shuffle or reset.
- o_Card/o_Value/o_Suit hold between deals.

Optional Feature:
- Macro: CARD_DEALER_REMAINING_EN.
- Defined: adds output port o_Remaining [5:0], equal to 52 - dealt count.
  - Reset and shuffle value: 52.
  - Decrements in the same cycle o_Valid rises.
- Undefined: the port does not exist. Behaviour is otherwise identical; the dealt count is kept internally only for o_DeckEmpty.

Decomposition:
- Package card_pkg holds:
  - constants DECK_SIZE=52, RANKS=13, SUITS=4;
  - the state enum type (IDLE, PROBE, DONE);
  - pure functions idx_to_rank, idx_to_suit and rank_to_value.
  - The score display and the game FSM share these.
- Natural sub-module: card_decode.
  - Combinational: idx → rank, value, suit.
  - Reusable by the score display.
- Bitmap, seed mapping and FSM stay in card_dealer.

Test Plan:
- Reset with i_Count=37 → all outputs 0. Then i_Deal pulse → o_Valid 2 cycles later, o_Card=12, o_Value=10, o_Suit=2.
- i_Count=60 → idx 8: o_Card=9, o_Value=9, o_Suit=0. Deal again with i_Count=8 → probe skips to idx 9: o_Card=10, o_Suit=0, latency 3.
- 52 deals with i_Count held at 0 → 52 distinct indices 0..51, latencies 2..53, o_DeckEmpty=1 after the last. A 53rd i_Deal gives no o_Valid and o_Busy stays 0.
- i_Shuffle asserted during PROBE of a long probe → no o_Valid, state IDLE, o_DeckEmpty=0. Next deal with i_Count=0 returns idx 0 (o_Card=1, o_Value=1).
- i_Deal and i_Shuffle both high in the same IDLE cycle → no deal starts; the next i_Deal works normally.
- i_Reset pulled low asynchronously mid-PROBE → outputs 0 immediately, no o_Valid. With CARD_DEALER_REMAINING_EN defined, o_Remaining=52 after reset and 51 after one deal.
